// File: rtl/spi_arb.sv
// Two-port round-robin arbiter sharing one SPI monarch between two serfs.
// Latches requester commands, routes SS_n/MISO to the granted serf.
module spi_arb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt0,
    input  logic [15:0] cmd0,
    output logic        done0,
    output logic [15:0] rd_data0,
    output logic        ovr0,
    input  logic        wrt1,
    input  logic [15:0] cmd1,
    output logic        done1,
    output logic [15:0] rd_data1,
    output logic        ovr1,
    output logic        m_wrt,
    output logic [15:0] m_cmd,
    input  logic        m_done,
    input  logic [15:0] m_rd_data,
    input  logic        m_SS_n,
    output logic        SS0_n,
    output logic        SS1_n,
    input  logic        MISO0,
    input  logic        MISO1,
    output logic        m_MISO,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, LAUNCH, XFER} state_t;

    state_t      state_q, state_d;
    logic        pend0_q, pend0_d;
    logic        pend1_q, pend1_d;
    logic [15:0] cmd_reg0_q, cmd_reg0_d;
    logic [15:0] cmd_reg1_q, cmd_reg1_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        m_wrt_q, m_wrt_d;
    logic [15:0] m_cmd_q, m_cmd_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic [15:0] rd_data0_q, rd_data0_d;
    logic [15:0] rd_data1_q, rd_data1_d;
    logic        ovr0_q, ovr0_d;
    logic        ovr1_q, ovr1_d;
    logic        grant;
    logic        fin0;
    logic        fin1;

    always_comb begin
        state_d    = state_q;
        pend0_d    = pend0_q;
        pend1_d    = pend1_q;
        cmd_reg0_d = cmd_reg0_q;
        cmd_reg1_d = cmd_reg1_q;
        last_d     = last_q;
        owner_d    = owner_q;
        m_wrt_d    = 1'b0;
        m_cmd_d    = m_cmd_q;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        rd_data0_d = rd_data0_q;
        rd_data1_d = rd_data1_q;
        ovr0_d     = 1'b0;
        ovr1_d     = 1'b0;

        fin0  = (state_q == XFER) && m_done && !owner_q;
        fin1  = (state_q == XFER) && m_done && owner_q;
        // On a tie the port that did not go last wins
        grant = (pend0_q && pend1_q) ? ~last_q : ~pend0_q;

        unique case (state_q)
            IDLE: begin
                if (pend0_q || pend1_q) begin
                    owner_d = grant;
                    m_cmd_d = grant ? cmd_reg1_q : cmd_reg0_q;
                    m_wrt_d = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: state_d = XFER;
            XFER: begin
                if (m_done) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    if (owner_q) begin
                        rd_data1_d = m_rd_data;
                        done1_d    = 1'b1;
                    end else begin
                        rd_data0_d = m_rd_data;
                        done0_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A new request in the completing cycle re-arms the port
        if (fin0) pend0_d = 1'b0;
        if (fin1) pend1_d = 1'b0;
        if (wrt0) begin
            if (!pend0_q || fin0) begin
                pend0_d    = 1'b1;
                cmd_reg0_d = cmd0;
            end else begin
                ovr0_d = 1'b1;
            end
        end
        if (wrt1) begin
            if (!pend1_q || fin1) begin
                pend1_d    = 1'b1;
                cmd_reg1_d = cmd1;
            end else begin
                ovr1_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend0_q    <= 1'b0;
            pend1_q    <= 1'b0;
            cmd_reg0_q <= 16'h0;
            cmd_reg1_q <= 16'h0;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            m_wrt_q    <= 1'b0;
            m_cmd_q    <= 16'h0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            rd_data0_q <= 16'h0;
            rd_data1_q <= 16'h0;
            ovr0_q     <= 1'b0;
            ovr1_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            cmd_reg0_q <= cmd_reg0_d;
            cmd_reg1_q <= cmd_reg1_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            m_wrt_q    <= m_wrt_d;
            m_cmd_q    <= m_cmd_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            rd_data0_q <= rd_data0_d;
            rd_data1_q <= rd_data1_d;
            ovr0_q     <= ovr0_d;
            ovr1_q     <= ovr1_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;
    assign m_wrt    = m_wrt_q;
    assign m_cmd    = m_cmd_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign rd_data0 = rd_data0_q;
    assign rd_data1 = rd_data1_q;
    assign ovr0     = ovr0_q;
    assign ovr1     = ovr1_q;
    assign SS0_n    = (busy && !owner_q) ? m_SS_n : 1'b1;
    assign SS1_n    = (busy && owner_q) ? m_SS_n : 1'b1;
    assign m_MISO   = owner_q ? MISO1 : MISO0;

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: per-cycle vector table plus
// hand-written contention, overrun, re-request and reset sequences.
module tb_spi_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wrt0, wrt1;
    logic [15:0] cmd0, cmd1;
    logic        done0, done1, ovr0, ovr1;
    logic [15:0] rd_data0, rd_data1;
    logic        m_wrt, m_done, m_SS_n;
    logic [15:0] m_cmd, m_rd_data;
    logic        SS0_n, SS1_n, MISO0, MISO1, m_MISO;
    logic        busy, owner;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [15:0] Z = 16'h0;

    spi_arb dut (
        .clk(clk), .rst_n(rst_n),
        .wrt0(wrt0), .cmd0(cmd0), .done0(done0),
        .rd_data0(rd_data0), .ovr0(ovr0),
        .wrt1(wrt1), .cmd1(cmd1), .done1(done1),
        .rd_data1(rd_data1), .ovr1(ovr1),
        .m_wrt(m_wrt), .m_cmd(m_cmd), .m_done(m_done),
        .m_rd_data(m_rd_data), .m_SS_n(m_SS_n),
        .SS0_n(SS0_n), .SS1_n(SS1_n),
        .MISO0(MISO0), .MISO1(MISO1), .m_MISO(m_MISO),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w0;
        logic [15:0] c0;
        logic        w1;
        logic [15:0] c1;
        logic        md;
        logic [15:0] mrd;
        logic        mss;
        logic        mi0;
        logic        mi1;
        logic        e_mw;
        logic [15:0] e_mc;
        logic        e_d0;
        logic        e_d1;
        logic [15:0] e_r0;
        logic [15:0] e_r1;
        logic        e_busy;
        logic        e_own;
        logic        e_s0;
        logic        e_s1;
        logic        e_mm;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
        wrt0   = 1'b0;
        wrt1   = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        int nd;
        int nw;
        // w0 c0 w1 c1 md mrd mss mi0 mi1 | mw mc d0 d1 r0 r1 busy own s0 s1 mm
        tbl[0]  = '{H,16'hA611,H,16'h8F00,L,Z,H,L,L, L,Z,L,L,Z,Z,L,L,H,H,L};
        tbl[1]  = '{L,Z,L,Z,L,Z,H,L,L, L,Z,L,L,Z,Z,L,L,H,H,L};
        tbl[2]  = '{L,Z,L,Z,L,Z,H,L,H, H,16'hA611,L,L,Z,Z,H,L,H,H,L};
        tbl[3]  = '{L,Z,L,Z,H,16'h1234,L,H,L, L,Z,L,L,Z,Z,H,L,L,H,H};
        tbl[4]  = '{L,Z,L,Z,L,Z,H,L,L, L,Z,H,L,16'h1234,Z,L,L,H,H,L};
        tbl[5]  = '{L,Z,L,Z,L,Z,H,L,L, H,16'h8F00,L,L,16'h1234,Z,H,H,H,H,L};
        tbl[6]  = '{L,Z,L,Z,H,16'h5678,L,L,H, L,Z,L,L,16'h1234,Z,H,H,H,L,H};
        tbl[7]  = '{L,Z,L,Z,L,Z,H,L,L, L,Z,L,H,16'h1234,16'h5678,L,H,H,H,L};
        tbl[8]  = '{H,16'h0D02,L,Z,L,Z,H,L,L, L,Z,L,L,16'h1234,16'h5678,L,H,H,H,L};
        tbl[9]  = '{L,Z,L,Z,L,Z,H,L,L, L,Z,L,L,16'h1234,16'h5678,L,H,H,H,L};
        tbl[10] = '{L,Z,L,Z,L,Z,H,L,L, H,16'h0D02,L,L,16'h1234,16'h5678,H,L,H,H,L};
        tbl[11] = '{L,Z,L,Z,L,Z,L,H,L, L,Z,L,L,16'h1234,16'h5678,H,L,L,H,H};
        tbl[12] = '{L,Z,L,Z,H,16'h00A5,L,L,L, L,Z,L,L,16'h1234,16'h5678,H,L,L,H,L};
        tbl[13] = '{L,Z,L,Z,L,Z,H,L,L, L,Z,H,L,16'h00A5,16'h5678,L,L,H,H,L};
        tbl[14] = '{H,16'hA622,H,16'h8F00,L,Z,H,L,L, L,Z,L,L,16'h00A5,16'h5678,L,L,H,H,L};
        tbl[15] = '{L,Z,L,Z,L,Z,H,L,L, L,Z,L,L,16'h00A5,16'h5678,L,L,H,H,L};
        tbl[16] = '{L,Z,L,Z,L,Z,H,L,L, H,16'h8F00,L,L,16'h00A5,16'h5678,H,H,H,H,L};
        tbl[17] = '{L,Z,L,Z,H,16'hBEEF,L,L,L, L,Z,L,L,16'h00A5,16'h5678,H,H,H,L,L};
        tbl[18] = '{L,Z,L,Z,L,Z,H,L,L, L,Z,L,H,16'h00A5,16'hBEEF,L,H,H,H,L};
        tbl[19] = '{L,Z,L,Z,L,Z,H,L,L, H,16'hA622,L,L,16'h00A5,16'hBEEF,H,L,H,H,L};
        tbl[20] = '{L,Z,L,Z,H,16'hCAFE,H,L,L, L,Z,L,L,16'h00A5,16'hBEEF,H,L,H,H,L};
        tbl[21] = '{L,Z,L,Z,L,Z,H,L,L, L,Z,H,L,16'hCAFE,16'hBEEF,L,L,H,H,L};
        tbl[22] = '{L,Z,L,Z,L,Z,H,L,L, L,Z,L,L,16'hCAFE,16'hBEEF,L,L,H,H,L};

        rst_n = 1'b0;
        wrt0 = 1'b0; wrt1 = 1'b0; cmd0 = Z; cmd1 = Z;
        m_done = 1'b0; m_rd_data = Z; m_SS_n = 1'b0;
        MISO0 = 1'b0; MISO1 = 1'b0;
        #3;
        chk("rst m_wrt", m_wrt, 0);
        chk("rst m_cmd", m_cmd, 0);
        chk("rst busy", busy, 0);
        chk("rst owner", owner, 0);
        chk("rst SS0_n", SS0_n, 1);
        chk("rst SS1_n", SS1_n, 1);
        chk("rst done0", done0, 0);
        chk("rst done1", done1, 0);
        chk("rst ovr0", ovr0, 0);
        chk("rst ovr1", ovr1, 0);
        chk("rst rd0", rd_data0, 0);
        chk("rst rd1", rd_data1, 0);
        m_SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1;
            wrt0 = tbl[i].w0; cmd0 = tbl[i].c0;
            wrt1 = tbl[i].w1; cmd1 = tbl[i].c1;
            m_done = tbl[i].md; m_rd_data = tbl[i].mrd;
            m_SS_n = tbl[i].mss;
            MISO0 = tbl[i].mi0; MISO1 = tbl[i].mi1;
            @(negedge clk);
            chk($sformatf("v%0d m_wrt", i), m_wrt, tbl[i].e_mw);
            if (tbl[i].e_mw)
                chk($sformatf("v%0d m_cmd", i), m_cmd, tbl[i].e_mc);
            chk($sformatf("v%0d done0", i), done0, tbl[i].e_d0);
            chk($sformatf("v%0d done1", i), done1, tbl[i].e_d1);
            chk($sformatf("v%0d rd0", i), rd_data0, tbl[i].e_r0);
            chk($sformatf("v%0d rd1", i), rd_data1, tbl[i].e_r1);
            chk($sformatf("v%0d ovr0", i), ovr0, 0);
            chk($sformatf("v%0d ovr1", i), ovr1, 0);
            chk($sformatf("v%0d busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d owner", i), owner, tbl[i].e_own);
            chk($sformatf("v%0d SS0_n", i), SS0_n, tbl[i].e_s0);
            chk($sformatf("v%0d SS1_n", i), SS1_n, tbl[i].e_s1);
            chk($sformatf("v%0d m_MISO", i), m_MISO, tbl[i].e_mm);
        end
        MISO0 = 1'b0; MISO1 = 1'b0; m_SS_n = 1'b1;

        // Contention: port 1 requests during port 0 transfer
        clk1(); wrt0 = 1'b1; cmd0 = 16'h1111;
        clk1();
        clk1(); mid();
        chk("ct m_wrt p0", m_wrt, 1);
        chk("ct m_cmd p0", m_cmd, 16'h1111);
        clk1(); wrt1 = 1'b1; cmd1 = 16'h2222; mid();
        chk("ct m_wrt low", m_wrt, 0);
        clk1(); m_done = 1'b1; m_rd_data = 16'h0A0A;
        clk1(); mid();
        chk("ct done0", done0, 1);
        chk("ct gap m_wrt", m_wrt, 0);
        chk("ct gap busy", busy, 0);
        clk1(); mid();
        chk("ct m_wrt p1", m_wrt, 1);
        chk("ct m_cmd p1", m_cmd, 16'h2222);
        chk("ct owner p1", owner, 1);
        clk1(); m_done = 1'b1; m_rd_data = 16'h0B0B;
        clk1(); mid();
        chk("ct done1", done1, 1);
        chk("ct rd1", rd_data1, 16'h0B0B);
        chk("ct rd0 kept", rd_data0, 16'h0A0A);

        // Overrun: second wrt0 while port 0 pending
        clk1(); wrt0 = 1'b1; cmd0 = 16'h3333;
        clk1(); wrt0 = 1'b1; cmd0 = 16'h1160; mid();
        chk("ov ovr0 early", ovr0, 0);
        clk1(); mid();
        chk("ov ovr0", ovr0, 1);
        chk("ov m_wrt", m_wrt, 1);
        chk("ov m_cmd", m_cmd, 16'h3333);
        clk1(); m_done = 1'b1; m_rd_data = 16'h4444; mid();
        chk("ov ovr0 once", ovr0, 0);
        nd = 0; nw = 0;
        for (int i = 0; i < 5; i++) begin
            clk1(); mid();
            nd += int'(done0);
            nw += int'(m_wrt);
        end
        chk("ov done0 count", nd[15:0], 1);
        chk("ov no relaunch", nw[15:0], 0);
        chk("ov rd0", rd_data0, 16'h4444);

        // Re-request in the completion cycle
        clk1(); wrt0 = 1'b1; cmd0 = 16'h5555;
        clk1();
        clk1(); mid();
        chk("rr m_cmd1", m_cmd, 16'h5555);
        clk1(); m_done = 1'b1; m_rd_data = 16'h6666;
        wrt0 = 1'b1; cmd0 = 16'h7777;
        clk1(); mid();
        chk("rr done0", done0, 1);
        chk("rr ovr0", ovr0, 0);
        chk("rr rd0", rd_data0, 16'h6666);
        clk1(); mid();
        chk("rr m_wrt2", m_wrt, 1);
        chk("rr m_cmd2", m_cmd, 16'h7777);
        clk1(); m_done = 1'b1; m_rd_data = 16'h8888;
        clk1(); mid();
        chk("rr done0 2", done0, 1);
        chk("rr rd0 2", rd_data0, 16'h8888);

        // Reset during a port 1 transfer with port 0 pending
        clk1(); wrt1 = 1'b1; cmd1 = 16'h9999;
        clk1(); wrt0 = 1'b1; cmd0 = 16'hABCD;
        clk1(); mid();
        chk("rs m_cmd", m_cmd, 16'h9999);
        chk("rs owner", owner, 1);
        clk1(); m_SS_n = 1'b0; mid();
        chk("rs SS1_n low", SS1_n, 0);
        chk("rs SS0_n high", SS0_n, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs busy", busy, 0);
        chk("rs SS1_n", SS1_n, 1);
        chk("rs owner0", owner, 0);
        chk("rs m_cmd0", m_cmd, 0);
        chk("rs rd0", rd_data0, 0);
        chk("rs rd1", rd_data1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_SS_n = 1'b1;
        clk1(); m_done = 1'b1; m_rd_data = 16'hFFFF;
        nd = 0; nw = 0;
        for (int i = 0; i < 6; i++) begin
            clk1(); mid();
            nd += int'(done0) + int'(done1);
            nw += int'(m_wrt) + int'(busy);
        end
        chk("rs no done", nd[15:0], 0);
        chk("rs no launch", nw[15:0], 0);
        chk("rs rd1 clear", rd_data1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_arb.md
# spi_arb

Two-port arbiter that shares the single SPI monarch between two SPI requesters: port 0 is the inertial sensor interface, port 1 is a second serf device on the same SCLK/MOSI bus. It sits between the requesters and the SPI monarch. It latches each requester's 16-bit command, grants the monarch round-robin, and routes MISO and slave-select to the granted serf. It returns read data and a one-cycle done pulse to the owning requester.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wrt0  in  1  port 0 start pulse (1 clk); samples cmd0
- cmd0  in  16  port 0 command word
- done0  out  1  port 0 transaction complete, 1-clk pulse
- rd_data0  out  16  port 0 returned data; valid from done0 until the next port 0 completion
- ovr0  out  1  1-clk pulse: wrt0 dropped because port 0 already pending/in flight
- wrt1, cmd1, done1, rd_data1, ovr1  same as port 0 for port 1
- m_wrt  out  1  start pulse to monarch
- m_cmd  out  16  wt_data to monarch
- m_done  in  1  done from monarch
- m_rd_data  in  16  rd_data from monarch
- m_SS_n  in  1  SS_n from monarch
- SS0_n, SS1_n  out  1  per-serf slave selects
- MISO0, MISO1  in  1  per-serf MISO
- m_MISO  out  1  MISO to monarch
- busy  out  1  a transaction is granted or in flight
- owner  out  1  port currently or last granted

## Operation
- Each port has pendN flag and cmd_regN. A wrt pulse with pendN=0 sets pendN and captures cmdN. A wrt pulse with pendN=1 is discarded, pulses ovrN next cycle, and leaves cmd_regN unchanged.
- A request arriving for port X while the other port is in flight is latched. It is served after the current transaction.
- State machine has states IDLE, LAUNCH, XFER:
  - IDLE: if any pend is set, pick the grant. Only one pending means that port. Both pending means the port != last. Register owner=grant, m_cmd=cmd_reg[grant], m_wrt=1, go to LAUNCH.
  - LAUNCH: m_wrt returns 0 (exactly one cycle high), go to XFER.
  - XFER: wait for m_done. On m_done: rd_data[owner] <= m_rd_data, pulse done[owner] next cycle, clear pend[owner], last <= owner, go to IDLE.
- m_done seen outside XFER is ignored.
- busy = (state != IDLE).
- SS routing is combinational from the registered owner and busy:
  - SS0_n = busy && owner==0 ? m_SS_n : 1
  - SS1_n = busy && owner==1 ? m_SS_n : 1
  - m_MISO = owner ? MISO1 : MISO0
- wrt for port X in the same cycle m_done completes port X: pend clears, then the new request is accepted (clear has lower priority than set). No ovr pulse.
- Reset values:
  - state=IDLE; pend0=pend1=0; last=1, so port 0 wins the first tie.
  - owner=0, m_wrt=0, m_cmd=0.
  - done0/1=0, ovr0/1=0, rd_data0/1=0, busy=0, SS0_n=SS1_n=1.
- Reset mid-transaction: all state and pending requests are lost and no done is issued. The monarch shares rst_n.

## Timing
- wrt in cycle 0 with the arbiter idle: pend set in cycle 1, m_wrt high in cycle 2, busy high from cycle 2.
- m_done high in cycle k: doneN and rd_dataN updated in cycle k+1, and busy low in cycle k+1.
- The earliest next m_wrt is cycle k+2.
- ovrN is high in the cycle after the rejected wrt.
- Back-to-back service with no requester gap: one IDLE cycle between transactions (m_done → IDLE → m_wrt).

## Test plan
- Single request: wrt0 with cmd0=16'h0D02 while idle → m_wrt high for one cycle two cycles later with m_cmd=16'h0D02, SS0_n follows m_SS_n, SS1_n stays 1. Monarch returns 16'h00A5 → done0 pulses one cycle later with rd_data0=16'h00A5, and done1 stays 0.
- Tie after reset: wrt0 (16'hA6xx) and wrt1 (16'h8F00) in the same cycle → port 0 is served first, then port 1 automatically. Next tie → port 1 is served first.
- Contention: wrt1 issued during port 0's XFER → port 1 launches exactly two cycles after port 0's m_done. rd_data0 stays intact.
- Overrun: second wrt0 with cmd0=16'h1160 while port 0 is pending → ovr0 pulses once. The transferred m_cmd is the first command, and only one done0 is issued.
- Re-request on completion: wrt0 in the same cycle as m_done for port 0 → no ovr0 and a second port 0 transaction launches.
- Reset mid-XFER: assert rst_n low → all outputs return to reset values asynchronously. Pending requests are cleared and no done pulse is issued after release.
